// File: rtl/controle_rodada.sv
// Round sequencer: runs one game of NUM_RODADAS rounds and turns each answer or
// per-round timeout into a single acertou/errou pulse for the point counter.
module controle_rodada #(
    parameter int unsigned TIMEOUT_CICLOS = 1000,
    parameter int unsigned NUM_RODADAS    = 40,
    parameter int unsigned PONTOS_MAX     = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       jogada_correta,
    input  logic [5:0] pontos,
    output logic       acertou,
    output logic       errou,
    output logic       enable_pontos,
    output logic       zera_pontos,
    output logic       timeout,
    output logic       aguardando_jogada,
    output logic [5:0] rodada,
    output logic       fim_jogo,
    output logic       ganhou,
    output logic [2:0] estado_db
);

    localparam logic [2:0] INICIAL  = 3'd0;
    localparam logic [2:0] PREPARA  = 3'd1;
    localparam logic [2:0] ESPERA   = 3'd2;
    localparam logic [2:0] REGISTRA = 3'd3;
    localparam logic [2:0] PROXIMA  = 3'd4;
    localparam logic [2:0] FIM      = 3'd5;

    localparam logic [15:0] TIMER_FIM   = 16'(TIMEOUT_CICLOS - 1);
    localparam logic [5:0]  RODADAS_FIM = 6'(NUM_RODADAS);
    localparam logic [5:0]  PONTOS_FIM  = 6'(PONTOS_MAX);

    logic [2:0]  r_estado, w_estado;
    logic [15:0] r_timer, w_timer;
    logic [5:0]  r_rodada, w_rodada;
    logic        r_ganhou, w_ganhou;
    logic        r_veredito, w_veredito;
    logic        r_timeout, w_timeout;

    logic        w_expirou;
    logic        w_pontos_max;
    logic [5:0]  w_rodada_inc;
    logic        w_ultima;

    assign w_expirou    = (r_timer == TIMER_FIM);
    assign w_pontos_max = (pontos == PONTOS_FIM);
    assign w_rodada_inc = r_rodada + 6'd1;
    assign w_ultima     = (w_rodada_inc == RODADAS_FIM);

    always_comb begin
        w_estado   = r_estado;
        w_timer    = r_timer;
        w_rodada   = r_rodada;
        w_ganhou   = r_ganhou;
        w_veredito = r_veredito;
        w_timeout  = r_timeout;
        case (r_estado)
            INICIAL, FIM: begin
                // Clearing on the way in keeps rodada/ganhou at 0 already during PREPARA.
                if (iniciar) begin
                    w_estado  = PREPARA;
                    w_timer   = 16'd0;
                    w_rodada  = 6'd0;
                    w_ganhou  = 1'b0;
                    w_timeout = 1'b0;
                end
            end
            PREPARA: begin
                w_estado   = ESPERA;
                w_timer    = 16'd0;
                w_rodada   = 6'd0;
                w_ganhou   = 1'b0;
                w_veredito = 1'b0;
                w_timeout  = 1'b0;
            end
            ESPERA: begin
                // An answer arriving on the expiry cycle beats the timeout.
                if (jogada) begin
                    w_estado   = REGISTRA;
                    w_veredito = jogada_correta;
                    w_timeout  = 1'b0;
                end else if (w_expirou) begin
                    w_estado   = REGISTRA;
                    w_veredito = 1'b0;
                    w_timeout  = 1'b1;
                end else begin
                    w_timer = r_timer + 16'd1;
                end
            end
            REGISTRA: begin
                w_estado = PROXIMA;
            end
            PROXIMA: begin
                w_rodada = w_rodada_inc;
                if (w_pontos_max || w_ultima) begin
                    w_estado = FIM;
                    w_ganhou = w_pontos_max;
                end else begin
                    w_estado  = ESPERA;
                    w_timer   = 16'd0;
                    w_timeout = 1'b0;
                end
            end
            default: begin
                w_estado = INICIAL;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado   <= INICIAL;
            r_timer    <= 16'd0;
            r_rodada   <= 6'd0;
            r_ganhou   <= 1'b0;
            r_veredito <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_estado   <= w_estado;
            r_timer    <= w_timer;
            r_rodada   <= w_rodada;
            r_ganhou   <= w_ganhou;
            r_veredito <= w_veredito;
            r_timeout  <= w_timeout;
        end
    end

    // Moore decode from registered state only; no input reaches an output.
    always_comb begin
        acertou           = 1'b0;
        errou             = 1'b0;
        enable_pontos     = 1'b0;
        zera_pontos       = 1'b0;
        timeout           = 1'b0;
        aguardando_jogada = 1'b0;
        fim_jogo          = 1'b0;
        case (r_estado)
            PREPARA: zera_pontos = 1'b1;
            ESPERA:  aguardando_jogada = 1'b1;
            REGISTRA: begin
                acertou       = r_veredito;
                errou         = ~r_veredito;
                enable_pontos = 1'b1;
                timeout       = r_timeout;
            end
            FIM:     fim_jogo = 1'b1;
            default: ;
        endcase
    end

    assign rodada    = r_rodada;
    assign ganhou    = r_ganhou;
    assign estado_db = r_estado;

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!(acertou && errou))
                else $error("acertou and errou high together");
            assert (r_rodada <= RODADAS_FIM)
                else $error("rodada beyond NUM_RODADAS");
            assert (r_timer <= TIMER_FIM)
                else $error("timer beyond TIMEOUT_CICLOS-1");
        end
    end
`endif

endmodule

// File: doc/controle_rodada.md
# controle_rodada

Round sequencer for the point counter. Starts a game on `iniciar`, waits for each player answer with a per-round timeout, and converts each answer or timeout into exactly one single-cycle `acertou` or `errou` pulse toward `contador_pontos`. It ends the game after a fixed number of rounds, or as soon as the score reaches its maximum, and reports whether the player won. It sits between the input/answer-check logic and the point counter.

## Interface
- `TIMEOUT_CICLOS`, 1000: cycles allowed per round before a timeout. Range 2..65535.
- `NUM_RODADAS`, 40: rounds per game. Range 1..63.
- `PONTOS_MAX`, 32: score that ends the game as a win. Must match the counter saturation value.
- `clock` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `iniciar` in 1: start or restart request. Level-sampled; acted on only in INICIAL or FIM.
- `jogada` in 1: one-cycle pulse meaning an answer is available. Acted on only in ESPERA.
- `jogada_correta` in 1: answer verdict. Sampled in the same cycle as `jogada`.
- `pontos` in 6: current score from the point counter.
- `acertou` out 1: one-cycle pulse, answer correct.
- `errou` out 1: one-cycle pulse, answer wrong or timed out.
- `enable_pontos` out 1: counter enable. High only in the same cycle as `acertou` or `errou`.
- `zera_pontos` out 1: one-cycle pulse that clears the score at game start.
- `timeout` out 1: one-cycle pulse, coincident with `errou` when the round expired.
- `aguardando_jogada` out 1: high while in ESPERA.
- `rodada` out 6: number of completed rounds in the current game.
- `fim_jogo` out 1: high while in FIM.
- `ganhou` out 1: registered when entering FIM; held until the next PREPARA or reset.
- `estado_db` out 3: state encoding, for debug.

## Operation
- States: INICIAL=0, PREPARA=1, ESPERA=2, REGISTRA=3, PROXIMA=4, FIM=5. Codes 6 and 7 go to INICIAL on the next edge.
- Reset: the state becomes INICIAL. All outputs are 0, and the timer, `rodada`, `ganhou` and the latched verdict are cleared. Reset has priority over every other input and takes effect from any state, including mid-round.
- INICIAL: if `iniciar`=1, go to PREPARA.
- PREPARA (1 cycle):
  - `zera_pontos`=1.
  - `rodada`, the timer and `ganhou` are cleared.
  - Next state: ESPERA.
- ESPERA:
  - The 16-bit timer increments every cycle, starting from 0.
  - If `jogada`=1: latch `jogada_correta` and go to REGISTRA.
  - Otherwise, if the timer equals `TIMEOUT_CICLOS`-1: latch verdict=wrong, set the timeout flag, and go to REGISTRA.
  - If `jogada` arrives in the same cycle the timer expires, the answer wins and no timeout is recorded.
- REGISTRA (1 cycle):
  - Exactly one of `acertou` or `errou` is high, per the latched verdict.
  - `enable_pontos`=1.
  - `timeout`=1 only if the timeout flag is set.
  - Next state: PROXIMA.
- PROXIMA (1 cycle):
  - `rodada` increments by 1.
  - If `pontos` equals `PONTOS_MAX`, or the new `rodada` value equals `NUM_RODADAS`: go to FIM and latch `ganhou` = (`pontos` equals `PONTOS_MAX`).
  - Otherwise: clear the timer and the timeout flag, and return to ESPERA.
- FIM: `fim_jogo`=1. `rodada` and `ganhou` hold. If `iniciar`=1, go to PREPARA.
- Ignored inputs:
  - `jogada` outside ESPERA is ignored; it is neither queued nor counted.
  - `iniciar` in PREPARA, ESPERA, REGISTRA or PROXIMA is ignored.
- Width rules:
  - `rodada` never exceeds `NUM_RODADAS`.
  - The timer never exceeds `TIMEOUT_CICLOS`-1 and never wraps.
  - `pontos` is compared unsigned at its full 6 bits.

## Timing
- All outputs are registered Moore outputs decoded from the state, the latched verdict and the timeout flag. There is no combinational path from input to output.
- Answer to pulse: `jogada` sampled at edge N gives `acertou`/`errou` high during cycle N+1 (REGISTRA). The controller is back in ESPERA at cycle N+3.
- Timeout: the timer reaches `TIMEOUT_CICLOS`-1 at edge N, and `errou` with `timeout` is high during cycle N+1. A round with no answer lasts `TIMEOUT_CICLOS`+2 cycles, measured from ESPERA entry to ESPERA re-entry.
- The score is sampled in PROXIMA, one full cycle after the pulse, so the counter's updated value is seen.
- Pulse shape:
  - `acertou` and `errou` are never both high.
  - Each is high for exactly 1 cycle.
  - They are separated by at least 3 cycles.
- Game start: `iniciar` sampled at edge N gives `zera_pontos` during cycle N+1 and ESPERA from cycle N+2.

## Test plan
All scenarios use `TIMEOUT_CICLOS`=8 and `NUM_RODADAS`=4.
- Reset then `iniciar` -> `zera_pontos` is high for 1 cycle, then `aguardando_jogada`=1 and `rodada`=0.
- `jogada`=1 with `jogada_correta`=1 in ESPERA -> next cycle `acertou`=1 and `enable_pontos`=1, `errou`=0; `rodada`=1 two cycles after `jogada`.
- No `jogada` for 8 cycles -> `errou`=1 and `timeout`=1 for 1 cycle; `jogada` on the 8th ESPERA cycle -> answer accepted, `timeout`=0.
- 4 rounds with `pontos` held at 5 -> `fim_jogo`=1, `ganhou`=0, `rodada`=4; `jogada` pulses while in FIM produce no pulses; `iniciar` -> PREPARA and `rodada`=0.
- `pontos`=32 on the round-2 PROXIMA -> FIM with `ganhou`=1 and `rodada`=2.
- `reset`=1 during ESPERA, and again during REGISTRA -> next cycle all outputs are 0 and `estado_db`=0; `acertou`/`errou` is never seen after the reset edge.
